// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master engine: the FSM state encoding,
// the data word width and the chip-select decode.
package spi_pkg;

  localparam int SPI_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Active-low one-hot select: only the addressed device's bit is low.
  function automatic logic [3:0] cs_decode(input logic [1:0] sel);
    cs_decode = ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: the half-period counter runs only while enabled. It emits
// one-cycle strobes on the clk_i edge where sclk rises or falls.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en,
  output logic sclk,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc         = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_pulse = tc && !sclk;
  assign fall_pulse = tc && sclk;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tc) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_engine.sv
// 32-bit SPI mode-0 master: runs one full-duplex transfer per start request.
// Defining SPI_LOOPBACK_EN adds loopback_i, which routes mosi back into rx.
//
// state | meaning
// IDLE  | waiting for spi_start_i, all chip selects high
// SETUP | chip select asserted, mosi holds the MSB before the first sclk
// SHIFT | 32 sclk periods, sample on rise, shift out on fall
// HOLD  | chip select still asserted after the last falling edge
// DONE  | result published, waiting for spi_start_i to drop
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [SPI_WORD_W-1:0] spi_dat_i,
  input  logic                  spi_start_i,
  input  logic [1:0]            spi_sel_i,
  output logic [SPI_WORD_W-1:0] spi_dat_o,
  output logic                  spi_done_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
`ifdef SPI_LOOPBACK_EN
  input  logic                  loopback_i,
`endif
  output logic [3:0]            cs_n_o
);

  localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PW     = $clog2(PH_MAX + 1);

  state_t                state;
  logic [SPI_WORD_W-1:0] tx;
  logic [SPI_WORD_W-1:0] rx;
  logic [1:0]            sel;
  logic [5:0]            bit_cnt;
  logic [PW-1:0]         ph_cnt;
  logic                  rise_pulse;
  logic                  fall_pulse;
  logic                  sample;

  // mosi is the MSB of the tx shift register, so it is registered by construction.
  assign mosi_o = tx[SPI_WORD_W-1];

`ifdef SPI_LOOPBACK_EN
  logic lb;
  assign sample = lb ? mosi_o : miso_i;
`else
  assign sample = miso_i;
`endif

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .en         (state == SHIFT),
    .sclk       (sclk_o),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      tx         <= '0;
      rx         <= '0;
      sel        <= '0;
      bit_cnt    <= '0;
      ph_cnt     <= '0;
      cs_n_o     <= 4'hF;
      spi_dat_o  <= '0;
      spi_done_o <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      lb         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (spi_start_i) begin
            tx      <= spi_dat_i;
            sel     <= spi_sel_i;
            bit_cnt <= '0;
            ph_cnt  <= PW'(CS_SETUP);
            state   <= SETUP;
`ifdef SPI_LOOPBACK_EN
            lb      <= loopback_i;
`endif
          end
        end
        SETUP: begin
          // Select goes low one cycle after the latch; setup is timed from there.
`ifdef SPI_LOOPBACK_EN
          cs_n_o <= lb ? 4'hF : cs_decode(sel);
`else
          cs_n_o <= cs_decode(sel);
`endif
          if (ph_cnt == '0) state  <= SHIFT;
          else              ph_cnt <= ph_cnt - 1'b1;
        end
        SHIFT: begin
          if (rise_pulse) rx <= {rx[SPI_WORD_W-2:0], sample};
          if (fall_pulse) begin
            tx      <= {tx[SPI_WORD_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 6'd31) begin
              ph_cnt <= PW'(CS_HOLD - 1);
              state  <= HOLD;
            end
          end
        end
        HOLD: begin
          if (ph_cnt == '0) begin
            cs_n_o     <= 4'hF;
            spi_dat_o  <= rx;
            spi_done_o <= 1'b1;
            state      <= DONE;
          end else begin
            ph_cnt <= ph_cnt - 1'b1;
          end
        end
        DONE: begin
          if (!spi_start_i) begin
            spi_done_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          cs_n_o     <= 4'hF;
          spi_done_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Self-checking bench for spi_master_engine: directed and random transfers
// compared against a word-level model of the slave and the expected timing.
module tb_spi_master_engine;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int LAT      = CS_SETUP + 64 * CLK_DIV + CS_HOLD + 1;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] spi_dat_i;
  logic        spi_start_i;
  logic [1:0]  spi_sel_i;
  logic [31:0] spi_dat_o;
  logic        spi_done_o;
  logic        sclk_o;
  logic        mosi_o;
  logic        miso_i;
  logic [3:0]  cs_n_o;
`ifdef SPI_LOOPBACK_EN
  logic        loopback_i = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  spi_master_engine #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .spi_dat_i   (spi_dat_i),
    .spi_start_i (spi_start_i),
    .spi_sel_i   (spi_sel_i),
    .spi_dat_o   (spi_dat_o),
    .spi_done_o  (spi_done_o),
    .sclk_o      (sclk_o),
    .mosi_o      (mosi_o),
    .miso_i      (miso_i),
`ifdef SPI_LOOPBACK_EN
    .loopback_i  (loopback_i),
`endif
    .cs_n_o      (cs_n_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave model and bus monitor: running totals, sampled per transfer as deltas.
  int          rise_total   = 0;
  int          fall_total   = 0;
  int          fall_base    = 0;
  int          cs_err_total = 0;
  logic [31:0] mosi_cap     = '0;
  logic [31:0] slave_word   = '0;
  logic [3:0]  exp_cs       = 4'hF;

  always @(posedge sclk_o) begin
    rise_total++;
    mosi_cap = {mosi_cap[30:0], mosi_o};
    if (cs_n_o !== exp_cs) cs_err_total++;
  end

  always @(negedge sclk_o) fall_total++;

  always @* begin
    int idx;
    idx    = fall_total - fall_base;
    miso_i = (idx >= 0 && idx < 32) ? slave_word[31 - idx] : 1'b0;
  end

  task automatic run_xfer(input logic [31:0] tx, input logic [1:0] sel, input logic [31:0] slave,
                          input bit lb, input int drop_at, input int alter_at, input int hold_cyc,
                          input string nm);
    int          n;
    int          r0;
    int          c0;
    int          hold_bad;
    logic [31:0] exp_rx;
    logic [3:0]  ecs;
    exp_rx = lb ? tx : slave;
    ecs    = lb ? 4'hF : ~(4'b0001 << sel);
    @(negedge clk_i);
    spi_dat_i  = tx;
    spi_sel_i  = sel;
    slave_word = slave;
    fall_base  = fall_total;
    exp_cs     = ecs;
    r0         = rise_total;
    c0         = cs_err_total;
`ifdef SPI_LOOPBACK_EN
    loopback_i = lb;
`endif
    spi_start_i = 1'b1;
    @(posedge clk_i);
    n = 0;
    while (n < 2000 && spi_done_o !== 1'b1) begin
      @(posedge clk_i);
      #1;
      n++;
      if (n == drop_at) spi_start_i = 1'b0;
      if (n == alter_at) begin
        spi_dat_i = 32'hFFFF_FFFF;
        spi_sel_i = 2'd0;
      end
    end
    chk({nm, " done latency"}, n, LAT);
    chk({nm, " rx word"}, spi_dat_o, exp_rx);
    chk({nm, " mosi word"}, mosi_cap, tx);
    chk({nm, " sclk rises"}, rise_total - r0, 32);
    chk({nm, " cs during xfer"}, cs_err_total - c0, 0);
    chk({nm, " cs after done"}, {28'd0, cs_n_o}, 32'hF);
    chk({nm, " sclk idle"}, {31'd0, sclk_o}, 0);
    if (drop_at > 0) begin
      @(posedge clk_i);
      #1;
      chk({nm, " done one cycle"}, {31'd0, spi_done_o}, 0);
    end else begin
      hold_bad = 0;
      for (int i = 0; i < hold_cyc; i++) begin
        @(posedge clk_i);
        #1;
        if (cs_n_o !== 4'hF || spi_done_o !== 1'b1 || sclk_o !== 1'b0) hold_bad++;
      end
      chk({nm, " no retrigger"}, hold_bad, 0);
      spi_start_i = 1'b0;
      @(posedge clk_i);
      #1;
      chk({nm, " done clears"}, {31'd0, spi_done_o}, 0);
      chk({nm, " rx holds"}, spi_dat_o, exp_rx);
    end
    exp_cs = 4'hF;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i   = 1'b0;
    spi_start_i = 1'b0;
    spi_dat_i   = '0;
    spi_sel_i   = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset cs", {28'd0, cs_n_o}, 32'hF);
    chk("reset sclk", {31'd0, sclk_o}, 0);
    chk("reset mosi", {31'd0, mosi_o}, 0);
    chk("reset done", {31'd0, spi_done_o}, 0);
    chk("reset dat", spi_dat_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    run_xfer(32'hA5A5_0F0F, 2'd2, 32'h1234_5678, 1'b0, 0, 0, 100, "basic");
    run_xfer(32'h0123_4567, 2'd3, 32'h89AB_CDEF, 1'b0, 0, 0, 0, "again");
    run_xfer(32'hC3C3_3C3C, 2'd1, 32'h0F0F_F0F0, 1'b0, 0, 100, 0, "alter");
    run_xfer(32'h8000_0001, 2'd0, 32'hFFFF_FFFF, 1'b0, 10, 0, 0, "early drop");
    for (int k = 0; k < 4; k++)
      run_xfer($urandom, 2'($urandom_range(0, 3)), $urandom, 1'b0, 0, 0,
               $urandom_range(0, 5), "random");
`ifdef SPI_LOOPBACK_EN
    run_xfer(32'hDEAD_BEEF, 2'd1, 32'h1234_0000, 1'b1, 0, 0, 3, "loopback");
    loopback_i = 1'b0;
`endif

    // Reset in the middle of SHIFT.
    @(negedge clk_i);
    spi_dat_i   = 32'h5555_AAAA;
    spi_sel_i   = 2'd1;
    exp_cs      = 4'b1101;
    spi_start_i = 1'b1;
    repeat (60) @(posedge clk_i);
    #1;
    chk("mid shift cs", {28'd0, cs_n_o}, 32'hD);
    reset_n_i   = 1'b0;
    spi_start_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("mid reset cs", {28'd0, cs_n_o}, 32'hF);
    chk("mid reset sclk", {31'd0, sclk_o}, 0);
    chk("mid reset done", {31'd0, spi_done_o}, 0);
    chk("mid reset dat", spi_dat_o, 0);
    repeat (4) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    exp_cs    = 4'hF;

    run_xfer(32'h3C5A_96E1, 2'd2, 32'h7E81_18E7, 1'b0, 0, 0, 2, "post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
